d_e_stage_reg: RTL and testbench

//  D/E pipeline register of the 5-stage MIPS core, with built-in Tuse/Tnew stall detection.
//  - Each cycle it captures the decoded D-stage instruction into the E stage.
//  - On a data hazard it freezes F/D (D_stall) and loads a bubble (nop) into E instead.
//  - Its E_op/E_fuc/E_GRF_* outputs drive the E-stage controller.
//  - That controller returns E_Tnew, which this block uses for stall decisions.

---
 rtl/d_e_stage_reg.sv | 153 +++++++++++++++
 tb/tb_d_e_stage_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/d_e_stage_reg.sv
// D/E pipeline register of the 5-stage MIPS core. It also decides whether D must stall
// by comparing Tuse of the D instruction against Tnew of the instructions in E and M.
module d_e_stage_reg #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       D_op,
    input  logic [5:0]       D_fuc,
    input  logic [4:0]       D_GRF_A1,
    input  logic [4:0]       D_GRF_A2,
    input  logic [4:0]       D_GRF_A3,
    input  logic [31:0]      D_RD1,
    input  logic [31:0]      D_RD2,
    input  logic [31:0]      D_imm32,
    input  logic [31:0]      D_PC,
    input  logic [1:0]       E_Tnew,
    input  logic [4:0]       M_GRF_A3,
    input  logic [1:0]       M_Tnew,
    output logic             D_stall,
    output logic [5:0]       E_op,
    output logic [5:0]       E_fuc,
    output logic [4:0]       E_GRF_A1,
    output logic [4:0]       E_GRF_A2,
    output logic [4:0]       E_GRF_A3,
    output logic [31:0]      E_RD1,
    output logic [31:0]      E_RD2,
    output logic [31:0]      E_imm32,
    output logic [31:0]      E_PC,
    output logic [31:0]      E_PC8,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_ADDEI   = 6'b110011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] FUC_ADD    = 6'b100000;
    localparam logic [5:0] FUC_SUB    = 6'b100010;
    localparam logic [5:0] FUC_JR     = 6'b001000;

    logic [5:0]       r_op;
    logic [5:0]       r_fuc;
    logic [4:0]       r_a1;
    logic [4:0]       r_a2;
    logic [4:0]       r_a3;
    logic [31:0]      r_rd1;
    logic [31:0]      r_rd2;
    logic [31:0]      r_imm32;
    logic [31:0]      r_pc;
    logic [31:0]      r_pc8;
    logic [CNT_W-1:0] r_stallCnt;

    logic [1:0] w_tuseRs;
    logic [1:0] w_tuseRt;
    logic       w_stallRsE;
    logic       w_stallRsM;
    logic       w_stallRtE;
    logic       w_stallRtM;
    logic       w_stall;

    // Tuse of 3 marks an operand the instruction never reads, so it can never stall.
    always_comb begin
        w_tuseRs = 2'd3;
        w_tuseRt = 2'd3;
        case (D_op)
            OP_SPECIAL: begin
                if (D_fuc == FUC_ADD || D_fuc == FUC_SUB) begin
                    w_tuseRs = 2'd1;
                    w_tuseRt = 2'd1;
                end else if (D_fuc == FUC_JR) begin
                    w_tuseRs = 2'd0;
                end
            end
            OP_BEQ: begin
                w_tuseRs = 2'd0;
                w_tuseRt = 2'd0;
            end
            OP_ORI, OP_LW, OP_ADDEI: w_tuseRs = 2'd1;
            OP_SW: begin
                w_tuseRs = 2'd1;
                w_tuseRt = 2'd2;
            end
            default: begin
                w_tuseRs = 2'd3;
                w_tuseRt = 2'd3;
            end
        endcase
    end

    assign w_stallRsE = (D_GRF_A1 != 5'd0) && (D_GRF_A1 == r_a3)     && (w_tuseRs < E_Tnew);
    assign w_stallRsM = (D_GRF_A1 != 5'd0) && (D_GRF_A1 == M_GRF_A3) && (w_tuseRs < M_Tnew);
    assign w_stallRtE = (D_GRF_A2 != 5'd0) && (D_GRF_A2 == r_a3)     && (w_tuseRt < E_Tnew);
    assign w_stallRtM = (D_GRF_A2 != 5'd0) && (D_GRF_A2 == M_GRF_A3) && (w_tuseRt < M_Tnew);
    assign w_stall    = w_stallRsE || w_stallRsM || w_stallRtE || w_stallRtM;

    // A stalled cycle sends a bubble down but keeps the PC so E still knows where it is.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op       <= 6'd0;
            r_fuc      <= 6'd0;
            r_a1       <= 5'd0;
            r_a2       <= 5'd0;
            r_a3       <= 5'd0;
            r_rd1      <= 32'd0;
            r_rd2      <= 32'd0;
            r_imm32    <= 32'd0;
            r_pc       <= PC_RESET;
            r_pc8      <= PC_RESET + 32'd8;
            r_stallCnt <= '0;
        end else if (w_stall) begin
            r_op       <= 6'd0;
            r_fuc      <= 6'd0;
            r_a1       <= 5'd0;
            r_a2       <= 5'd0;
            r_a3       <= 5'd0;
            r_rd1      <= 32'd0;
            r_rd2      <= 32'd0;
            r_imm32    <= 32'd0;
            r_pc       <= D_PC;
            r_pc8      <= D_PC + 32'd8;
            r_stallCnt <= r_stallCnt + CNT_W'(1);
        end else begin
            r_op       <= D_op;
            r_fuc      <= D_fuc;
            r_a1       <= D_GRF_A1;
            r_a2       <= D_GRF_A2;
            r_a3       <= D_GRF_A3;
            r_rd1      <= D_RD1;
            r_rd2      <= D_RD2;
            r_imm32    <= D_imm32;
            r_pc       <= D_PC;
            r_pc8      <= D_PC + 32'd8;
        end
    end

    assign D_stall   = w_stall;
    assign E_op      = r_op;
    assign E_fuc     = r_fuc;
    assign E_GRF_A1  = r_a1;
    assign E_GRF_A2  = r_a2;
    assign E_GRF_A3  = r_a3;
    assign E_RD1     = r_rd1;
    assign E_RD2     = r_rd2;
    assign E_imm32   = r_imm32;
    assign E_PC      = r_pc;
    assign E_PC8     = r_pc8;
    assign stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_d_e_stage_reg.sv
// Bench for d_e_stage_reg: a table of D-stage instructions with expected stall decisions,
// and a queue of expected E-stage contents compared one clock later.
module tb_d_e_stage_reg;

    logic        clk;
    logic        reset;
    logic [5:0]  D_op;
    logic [5:0]  D_fuc;
    logic [4:0]  D_GRF_A1;
    logic [4:0]  D_GRF_A2;
    logic [4:0]  D_GRF_A3;
    logic [31:0] D_RD1;
    logic [31:0] D_RD2;
    logic [31:0] D_imm32;
    logic [31:0] D_PC;
    logic [1:0]  E_Tnew;
    logic [4:0]  M_GRF_A3;
    logic [1:0]  M_Tnew;
    logic        D_stall;
    logic [5:0]  E_op;
    logic [5:0]  E_fuc;
    logic [4:0]  E_GRF_A1;
    logic [4:0]  E_GRF_A2;
    logic [4:0]  E_GRF_A3;
    logic [31:0] E_RD1;
    logic [31:0] E_RD2;
    logic [31:0] E_imm32;
    logic [31:0] E_PC;
    logic [31:0] E_PC8;
    logic [31:0] stall_cnt;

    d_e_stage_reg #(.PC_RESET(32'h0000_3000), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .D_op(D_op), .D_fuc(D_fuc),
        .D_GRF_A1(D_GRF_A1), .D_GRF_A2(D_GRF_A2), .D_GRF_A3(D_GRF_A3),
        .D_RD1(D_RD1), .D_RD2(D_RD2), .D_imm32(D_imm32), .D_PC(D_PC),
        .E_Tnew(E_Tnew), .M_GRF_A3(M_GRF_A3), .M_Tnew(M_Tnew),
        .D_stall(D_stall),
        .E_op(E_op), .E_fuc(E_fuc),
        .E_GRF_A1(E_GRF_A1), .E_GRF_A2(E_GRF_A2), .E_GRF_A3(E_GRF_A3),
        .E_RD1(E_RD1), .E_RD2(E_RD2), .E_imm32(E_imm32),
        .E_PC(E_PC), .E_PC8(E_PC8), .stall_cnt(stall_cnt)
    );

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fuc;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic [31:0] pc;
        logic [1:0]  eTnew;
        logic [4:0]  mA3;
        logic [1:0]  mTnew;
        logic        expStall;
    } vec_t;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fuc;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [31:0] cnt;
    } eExp_t;

    vec_t  vecs[$];
    eExp_t scoreboard[$];
    int    vecCount  = 0;
    int    missCount = 0;
    logic [31:0] mdlCnt = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input string name, input logic [5:0] op, input logic [5:0] fuc,
                                   input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                                   input logic [31:0] pc, input logic [1:0] eTnew,
                                   input logic [4:0] mA3, input logic [1:0] mTnew, input logic expStall);
        vec_t v;
        v.name = name; v.op = op; v.fuc = fuc; v.a1 = a1; v.a2 = a2; v.a3 = a3; v.pc = pc;
        v.eTnew = eTnew; v.mA3 = mA3; v.mTnew = mTnew; v.expStall = expStall;
        return v;
    endfunction

    task automatic checkField(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, exp);
        end
    endtask

    // Pops the oldest expectation and compares it with what the DUT presents on E.
    task automatic checkOutput();
        eExp_t e;
        if (scoreboard.size() == 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = scoreboard.pop_front();
        checkField(e.name, "E_op",      {26'd0, E_op},     {26'd0, e.op});
        checkField(e.name, "E_fuc",     {26'd0, E_fuc},    {26'd0, e.fuc});
        checkField(e.name, "E_GRF_A1",  {27'd0, E_GRF_A1}, {27'd0, e.a1});
        checkField(e.name, "E_GRF_A2",  {27'd0, E_GRF_A2}, {27'd0, e.a2});
        checkField(e.name, "E_GRF_A3",  {27'd0, E_GRF_A3}, {27'd0, e.a3});
        checkField(e.name, "E_RD1",     E_RD1,     e.rd1);
        checkField(e.name, "E_RD2",     E_RD2,     e.rd2);
        checkField(e.name, "E_imm32",   E_imm32,   e.imm);
        checkField(e.name, "E_PC",      E_PC,      e.pc);
        checkField(e.name, "E_PC8",     E_PC8,     e.pc8);
        checkField(e.name, "stall_cnt", stall_cnt, e.cnt);
    endtask

    // Drives one D instruction, checks the same-cycle stall, queues the expected E contents.
    task automatic applyStimulus(input vec_t v, input logic rst);
        eExp_t e;
        @(negedge clk);
        reset    = rst;
        D_op     = v.op;
        D_fuc    = v.fuc;
        D_GRF_A1 = v.a1;
        D_GRF_A2 = v.a2;
        D_GRF_A3 = v.a3;
        D_PC     = v.pc;
        D_RD1    = v.pc ^ 32'h1111_1111;
        D_RD2    = v.pc ^ 32'h2222_2222;
        D_imm32  = {16'hBEEF, v.pc[15:0]};
        E_Tnew   = v.eTnew;
        M_GRF_A3 = v.mA3;
        M_Tnew   = v.mTnew;
        #1;
        checkField(v.name, "D_stall", {31'd0, D_stall}, {31'd0, v.expStall});
        e.name = v.name;
        if (rst) begin
            mdlCnt = 32'd0;
            e.op = 6'd0; e.fuc = 6'd0; e.a1 = 5'd0; e.a2 = 5'd0; e.a3 = 5'd0;
            e.rd1 = 32'd0; e.rd2 = 32'd0; e.imm = 32'd0;
            e.pc = 32'h0000_3000; e.pc8 = 32'h0000_3008;
        end else if (v.expStall) begin
            mdlCnt = mdlCnt + 32'd1;
            e.op = 6'd0; e.fuc = 6'd0; e.a1 = 5'd0; e.a2 = 5'd0; e.a3 = 5'd0;
            e.rd1 = 32'd0; e.rd2 = 32'd0; e.imm = 32'd0;
            e.pc = v.pc; e.pc8 = v.pc + 32'd8;
        end else begin
            e.op = v.op; e.fuc = v.fuc; e.a1 = v.a1; e.a2 = v.a2; e.a3 = v.a3;
            e.rd1 = D_RD1; e.rd2 = D_RD2; e.imm = D_imm32;
            e.pc = v.pc; e.pc8 = v.pc + 32'd8;
        end
        e.cnt = mdlCnt;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        reset = 1'b1;
        D_op = '0; D_fuc = '0; D_GRF_A1 = '0; D_GRF_A2 = '0; D_GRF_A3 = '0;
        D_RD1 = '0; D_RD2 = '0; D_imm32 = '0; D_PC = '0;
        E_Tnew = '0; M_GRF_A3 = '0; M_Tnew = '0;

        // Table entries run back to back; each row's E-stage state is the row before it.
        vecs.push_back(mkVec("lw_r1",        6'b100011, 6'd0,      5'd2, 5'd1, 5'd1, 32'h0000_3000, 2'd0, 5'd0, 2'd0, 1'b0));
        vecs.push_back(mkVec("add_hazE",     6'b000000, 6'b100000, 5'd1, 5'd3, 5'd2, 32'h0000_3004, 2'd2, 5'd0, 2'd0, 1'b1));
        vecs.push_back(mkVec("add_resolveM", 6'b000000, 6'b100000, 5'd1, 5'd3, 5'd2, 32'h0000_3004, 2'd0, 5'd1, 2'd1, 1'b0));
        vecs.push_back(mkVec("lw_r1_again",  6'b100011, 6'd0,      5'd0, 5'd1, 5'd1, 32'h0000_3008, 2'd1, 5'd2, 2'd0, 1'b0));
        vecs.push_back(mkVec("beq_stallE",   6'b000100, 6'd0,      5'd1, 5'd0, 5'd0, 32'h0000_300C, 2'd2, 5'd2, 2'd0, 1'b1));
        vecs.push_back(mkVec("beq_stallM",   6'b000100, 6'd0,      5'd1, 5'd0, 5'd0, 32'h0000_300C, 2'd0, 5'd1, 2'd1, 1'b1));
        vecs.push_back(mkVec("beq_enter",    6'b000100, 6'd0,      5'd1, 5'd0, 5'd0, 32'h0000_300C, 2'd0, 5'd0, 2'd0, 1'b0));
        vecs.push_back(mkVec("ori_r0",       6'b001101, 6'd0,      5'd0, 5'd0, 5'd0, 32'h0000_3010, 2'd0, 5'd0, 2'd0, 1'b0));
        vecs.push_back(mkVec("r0_exempt",    6'b000100, 6'd0,      5'd0, 5'd0, 5'd0, 32'h0000_3014, 2'd1, 5'd0, 2'd2, 1'b0));
        vecs.push_back(mkVec("ori_r5",       6'b001101, 6'd0,      5'd0, 5'd5, 5'd5, 32'h0000_3018, 2'd0, 5'd0, 2'd0, 1'b0));
        vecs.push_back(mkVec("sw_tuse2",     6'b101011, 6'd0,      5'd0, 5'd5, 5'd0, 32'h0000_301C, 2'd2, 5'd0, 2'd0, 1'b0));
        vecs.push_back(mkVec("add_rt_hazM",  6'b000000, 6'b100000, 5'd0, 5'd7, 5'd6, 32'h0000_3020, 2'd0, 5'd7, 2'd2, 1'b1));
        vecs.push_back(mkVec("add_rt_ok",    6'b000000, 6'b100000, 5'd0, 5'd7, 5'd6, 32'h0000_3020, 2'd0, 5'd7, 2'd1, 1'b0));
        vecs.push_back(mkVec("jr_hazE",      6'b000000, 6'b001000, 5'd6, 5'd0, 5'd0, 32'h0000_3024, 2'd1, 5'd0, 2'd0, 1'b1));
        vecs.push_back(mkVec("lui_pcwrap",   6'b001111, 6'd0,      5'd0, 5'd8, 5'd8, 32'hFFFF_FFFC, 2'd0, 5'd8, 2'd2, 1'b0));

        applyStimulus(mkVec("reset_state", 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 2'd0, 5'd0, 2'd0, 1'b0), 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], 1'b0);
        end

        // lui $8 is now in E; an add reading $8 with E Tnew=2 stalls, but reset wins.
        applyStimulus(mkVec("reset_vs_stall", 6'b000000, 6'b100000, 5'd8, 5'd0, 5'd9, 32'h0000_4000, 2'd2, 5'd0, 2'd0, 1'b1), 1'b1);
        applyStimulus(mkVec("post_reset_add", 6'b000000, 6'b100000, 5'd8, 5'd0, 5'd9, 32'h0000_4000, 2'd2, 5'd0, 2'd0, 1'b0), 1'b0);

        if (scoreboard.size() != 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", scoreboard.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
